// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory block (opcodes, NOP word, FSM states).
package prog_mem_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    NOT   = 4'd5,
    LOAD  = 4'd6,
    STORE = 4'd7,
    NOP   = 4'd15
  } opcode_e;

  // Opcode sits in the low bits; every other field is zero.
  localparam logic [15:0] NOP_WORD = 16'(NOP);

  typedef enum logic {CLEAR, RUN} state_e;

  // Source of the fetch output register contents.
  typedef enum logic [1:0] {SelNop, SelMem, SelByp} out_sel_e;

endpackage

// File: rtl/prog_mem_if.sv
// Fetch/load bus between the fetch stage, the boot/debug loader and the program memory.
interface prog_mem_if #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 16
);
  logic               busy;
  logic               load_valid;
  logic               load_ready;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               fetch_req;
  logic               fetch_stall;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               addr_err;
  logic               parity_err;

  modport master (
    output load_valid, load_addr, load_data, fetch_req, fetch_stall, fetch_addr,
    input  busy, load_ready, fetch_valid, fetch_instr, addr_err, parity_err
  );

  modport slave (
    input  load_valid, load_addr, load_data, fetch_req, fetch_stall, fetch_addr,
    output busy, load_ready, fetch_valid, fetch_instr, addr_err, parity_err
  );
endinterface

// File: rtl/prog_mem_array.sv
// Program word storage: one write port, one synchronous read port whose output holds when idle.
// With PROG_MEM_PARITY_EN defined each word carries an even-parity bit checked on the read data.
module prog_mem_array #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 32
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o,
  output logic               rperr_o
);
`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned Width = INSTR_W + 1;
`else
  localparam int unsigned Width = INSTR_W;
`endif

  logic [Width-1:0] mem [DEPTH];
  logic [Width-1:0] rword_q;
  logic [Width-1:0] wword;

`ifdef PROG_MEM_PARITY_EN
  // Parity bit makes the stored word have an even number of ones.
  assign wword   = {^wdata_i, wdata_i};
  assign rperr_o = ^rword_q;
`else
  assign wword   = wdata_i;
  assign rperr_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wword;
    if (re_i) rword_q <= mem[raddr_i];
  end

  assign rdata_o = rword_q[INSTR_W-1:0];

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: NOP sweep after reset, registered fetch with write-first bypass and
// range checks. Parity checking is enabled by PROG_MEM_PARITY_EN (handled in prog_mem_array).
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned OPCODE_W = 4
) (
  input logic       clk,
  input logic       rst,
  prog_mem_if.slave bus
);
  localparam logic [INSTR_W-1:0] NopWord = INSTR_W'(NOP_WORD[OPCODE_W-1:0]);

  state_e             state_q;
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               busy_q;
  logic               ready_q;
  logic               run;
  logic               fetch_go;
  logic               load_go;
  logic               fetch_in;
  logic               load_in;
  logic               load_hit;
  logic               mem_we;
  logic               mem_re;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;
  logic               perr;
  out_sel_e           sel_q;
  logic [INSTR_W-1:0] byp_q;
  logic               valid_q;
  logic               aerr_q;
  logic               chk_q;

  assign run      = (state_q == RUN);
  assign fetch_go = run && bus.fetch_req && !bus.fetch_stall;
  assign load_go  = run && bus.load_valid;
  assign fetch_in = 32'(bus.fetch_addr) < DEPTH;
  assign load_in  = 32'(bus.load_addr) < DEPTH;
  assign load_hit = load_go && load_in && (bus.load_addr == bus.fetch_addr);

  // The clear sweep owns the write port until the FSM reaches RUN.
  assign mem_we    = run ? (load_go && load_in) : 1'b1;
  assign mem_waddr = run ? bus.load_addr : clr_cnt_q;
  assign mem_wdata = run ? bus.load_data : NopWord;
  assign mem_re    = fetch_go && fetch_in;

  prog_mem_array #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (bus.fetch_addr),
    .rdata_o (mem_rdata),
    .rperr_o (perr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (32'(clr_cnt_q) == DEPTH - 1) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        RUN: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sel_q   <= SelNop;
      byp_q   <= '0;
      aerr_q  <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      aerr_q <= (fetch_go && !fetch_in) || (load_go && !load_in);
      // Parity is only judged on the cycle a fresh memory word arrives.
      chk_q  <= mem_re && !load_hit;
      if (run && !bus.fetch_stall) valid_q <= bus.fetch_req;
      if (fetch_go) begin
        if (!fetch_in) begin
          sel_q <= SelNop;
        end else if (load_hit) begin
          sel_q <= SelByp;
          byp_q <= bus.load_data;
        end else begin
          sel_q <= SelMem;
        end
      end
    end
  end

  always_comb begin
    bus.fetch_instr = NopWord;
    unique case (sel_q)
      SelMem:  bus.fetch_instr = perr ? NopWord : mem_rdata;
      SelByp:  bus.fetch_instr = byp_q;
      default: bus.fetch_instr = NopWord;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.load_ready  = ready_q;
  assign bus.fetch_valid = valid_q;
  assign bus.addr_err    = aerr_q;
  assign bus.parity_err  = chk_q && perr;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Bench for prog_mem_ctrl: a DEPTH=32 and a DEPTH=20 instance share stimulus and are compared
// against a behavioural model; parity corruption is exercised when PROG_MEM_PARITY_EN is defined.
module tb_prog_mem_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 16;
  localparam int unsigned DEP [2] = '{32, 20};
  localparam logic [IW-1:0] NOPW = 16'h000F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          fetch_req = 1'b0;
  logic          fetch_stall = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [AW-1:0] fetch_addr = '0;
  logic [IW-1:0] load_data = '0;

  always #5 clk = ~clk;

  prog_mem_if #(.ADDR_W(AW), .INSTR_W(IW)) b32 ();
  prog_mem_if #(.ADDR_W(AW), .INSTR_W(IW)) b20 ();

  assign b32.load_valid  = load_valid;
  assign b32.load_addr   = load_addr;
  assign b32.load_data   = load_data;
  assign b32.fetch_req   = fetch_req;
  assign b32.fetch_stall = fetch_stall;
  assign b32.fetch_addr  = fetch_addr;
  assign b20.load_valid  = load_valid;
  assign b20.load_addr   = load_addr;
  assign b20.load_data   = load_data;
  assign b20.fetch_req   = fetch_req;
  assign b20.fetch_stall = fetch_stall;
  assign b20.fetch_addr  = fetch_addr;

  prog_mem_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(32), .OPCODE_W(4)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  prog_mem_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(20), .OPCODE_W(4)) dut20 (
    .clk (clk),
    .rst (rst),
    .bus (b20)
  );

  logic          busy_o  [2];
  logic          ready_o [2];
  logic          valid_o [2];
  logic          aerr_o  [2];
  logic          perr_o  [2];
  logic [IW-1:0] instr_o [2];

  assign busy_o[0]  = b32.busy;
  assign ready_o[0] = b32.load_ready;
  assign valid_o[0] = b32.fetch_valid;
  assign aerr_o[0]  = b32.addr_err;
  assign perr_o[0]  = b32.parity_err;
  assign instr_o[0] = b32.fetch_instr;
  assign busy_o[1]  = b20.busy;
  assign ready_o[1] = b20.load_ready;
  assign valid_o[1] = b20.fetch_valid;
  assign aerr_o[1]  = b20.addr_err;
  assign perr_o[1]  = b20.parity_err;
  assign instr_o[1] = b20.fetch_instr;

  // Behavioural model: cycles since reset, word contents, last fetch result.
  logic [IW-1:0] m_mem   [2][32];
  int unsigned   m_cyc   [2];
  logic          m_valid [2];
  logic          m_aerr  [2];
  logic [IW-1:0] m_instr [2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k]   = 0;
      m_valid[k] = 1'b0;
      m_aerr[k]  = 1'b0;
      m_instr[k] = NOPW;
      for (int a = 0; a < 32; a++) m_mem[k][a] = NOPW;
    end
  endfunction

  function automatic void model_step(int k);
    m_aerr[k] = 1'b0;
    if (m_cyc[k] < DEP[k]) begin
      m_cyc[k]++;
      return;
    end
    if (fetch_req && !fetch_stall) begin
      m_valid[k] = 1'b1;
      if (32'(fetch_addr) >= DEP[k]) begin
        m_instr[k] = NOPW;
        m_aerr[k]  = 1'b1;
      end else if (load_valid && load_addr == fetch_addr) begin
        m_instr[k] = load_data;
      end else begin
        m_instr[k] = m_mem[k][fetch_addr];
      end
    end else if (!fetch_stall) begin
      m_valid[k] = 1'b0;
    end
    if (load_valid) begin
      if (32'(load_addr) >= DEP[k]) m_aerr[k] = 1'b1;
      else m_mem[k][load_addr] = load_data;
    end
  endfunction

  task automatic tick();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid  = 1'b0;
    fetch_req   = 1'b0;
    fetch_stall = 1'b0;
    load_addr   = '0;
    fetch_addr  = '0;
    load_data   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy_o[k] !== 1'b1) $display("FAIL reset_busy[%0d]: got %b want 1", k, busy_o[k]);
      else n_pass++;
      n_checks++;
      if (ready_o[k] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b want 0", k, ready_o[k]);
      else n_pass++;
      n_checks++;
      if (valid_o[k] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", k, valid_o[k]);
      else n_pass++;
      n_checks++;
      if (instr_o[k] !== NOPW) $display("FAIL reset_instr[%0d]: got %h want %h", k, instr_o[k], NOPW);
      else n_pass++;
      n_checks++;
      if (aerr_o[k] !== 1'b0 || perr_o[k] !== 1'b0)
        $display("FAIL reset_errs[%0d]: got %b%b want 00", k, aerr_o[k], perr_o[k]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_clear();
    int unsigned busy_cnt [2] = '{0, 0};
    for (int i = 0; i < 36; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_o[k] === 1'b1) busy_cnt[k]++;
        n_checks++;
        if (busy_o[k] !== (m_cyc[k] < DEP[k]) || ready_o[k] !== (m_cyc[k] >= DEP[k]))
          $display("FAIL clear_busy[%0d] cyc %0d: got busy %b ready %b want busy %b",
                   k, i, busy_o[k], ready_o[k], m_cyc[k] < DEP[k]);
        else n_pass++;
        n_checks++;
        if (valid_o[k] !== m_valid[k])
          $display("FAIL clear_valid[%0d] cyc %0d: got %b want %b", k, i, valid_o[k], m_valid[k]);
        else n_pass++;
      end
      // Requests during the sweep must be ignored by both instances.
      if (i < 20) begin
        fetch_req  = 1'b1;
        fetch_addr = AW'($urandom);
        load_valid = 1'b1;
        load_addr  = AW'($urandom);
        load_data  = IW'($urandom);
      end else begin
        idle_inputs();
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy_cnt[k] !== DEP[k])
        $display("FAIL clear_len[%0d]: got %0d busy cycles want %0d", k, busy_cnt[k], DEP[k]);
      else n_pass++;
    end
    for (int a = 0; a < 32; a++) begin
      fetch_req  = 1'b1;
      fetch_addr = AW'(a);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (valid_o[k] !== 1'b1 || instr_o[k] !== 16'h000F)
          $display("FAIL clear_fetch[%0d] addr %0d: got %b/%h want 1/000f",
                   k, a, valid_o[k], instr_o[k]);
        else n_pass++;
        n_checks++;
        if (aerr_o[k] !== (32'(a) >= DEP[k]))
          $display("FAIL clear_aerr[%0d] addr %0d: got %b", k, a, aerr_o[k]);
        else n_pass++;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_fetch();
    load_valid = 1'b1;
    load_addr  = 5'd3;
    load_data  = 16'h0047;
    tick();
    idle_inputs();
    fetch_req  = 1'b1;
    fetch_addr = 5'd3;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_o[k] !== 1'b1 || instr_o[k] !== 16'h0047)
        $display("FAIL load_fetch[%0d]: got %b/%h want 1/0047", k, valid_o[k], instr_o[k]);
      else n_pass++;
    end
    idle_inputs();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_o[k] !== 1'b0) $display("FAIL no_req_valid[%0d]: got %b want 0", k, valid_o[k]);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    load_valid = 1'b1;
    load_addr  = 5'd5;
    load_data  = 16'h1230;
    fetch_req  = 1'b1;
    fetch_addr = 5'd5;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_o[k] !== 1'b1 || instr_o[k] !== 16'h1230)
        $display("FAIL bypass[%0d]: got %b/%h want 1/1230", k, valid_o[k], instr_o[k]);
      else n_pass++;
    end
    load_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (instr_o[k] !== 16'h1230)
        $display("FAIL bypass_stored[%0d]: got %h want 1230", k, instr_o[k]);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_out_of_range();
    logic [IW-1:0] want;
    fetch_req  = 1'b1;
    fetch_addr = 5'd25;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (valid_o[k] !== 1'b1 || instr_o[k] !== 16'h000F || aerr_o[k] !== (k == 1))
        $display("FAIL oor_fetch[%0d]: got %b/%h aerr %b", k, valid_o[k], instr_o[k], aerr_o[k]);
      else n_pass++;
    end
    fetch_req  = 1'b0;
    load_valid = 1'b1;
    load_addr  = 5'd25;
    load_data  = 16'hBEEF;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (aerr_o[k] !== (k == 1) || valid_o[k] !== 1'b0)
        $display("FAIL oor_load[%0d]: got aerr %b valid %b", k, aerr_o[k], valid_o[k]);
      else n_pass++;
    end
    load_valid = 1'b0;
    fetch_req  = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      want = (k == 1) ? 16'h000F : 16'hBEEF;
      n_checks++;
      if (instr_o[k] !== want)
        $display("FAIL oor_readback[%0d]: got %h want %h", k, instr_o[k], want);
      else n_pass++;
    end
    load_valid = 1'b1;
    load_addr  = 5'd26;
    load_data  = 16'h5555;
    fetch_addr = 5'd27;
    tick();
    idle_inputs();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (aerr_o[k] !== 1'b0) $display("FAIL oor_pulse[%0d]: got %b want 0", k, aerr_o[k]);
      else n_pass++;
    end
    fetch_req  = 1'b1;
    fetch_addr = 5'd6;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (instr_o[k] !== 16'h000F)
        $display("FAIL oor_alias[%0d]: got %h want 000f", k, instr_o[k]);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_reset();
    logic [AW-1:0] stall_addrs [3] = '{5'd5, 5'd9, 5'd25};
    fetch_req  = 1'b1;
    fetch_addr = 5'd3;
    tick();
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = stall_addrs[i];
      load_valid = (i == 1);
      load_addr  = 5'd3;
      load_data  = 16'hAAAA;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (valid_o[k] !== 1'b1 || instr_o[k] !== 16'h0047 || aerr_o[k] !== 1'b0)
          $display("FAIL stall_hold[%0d] cyc %0d: got %b/%h aerr %b want 1/0047 aerr 0",
                   k, i, valid_o[k], instr_o[k], aerr_o[k]);
        else n_pass++;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy_o[k] !== 1'b1 || ready_o[k] !== 1'b0 || valid_o[k] !== 1'b0 ||
          instr_o[k] !== NOPW || aerr_o[k] !== 1'b0 || perr_o[k] !== 1'b0)
        $display("FAIL stall_reset[%0d]: got busy %b ready %b valid %b instr %h errs %b%b",
                 k, busy_o[k], ready_o[k], valid_o[k], instr_o[k], aerr_o[k], perr_o[k]);
      else n_pass++;
    end
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      fetch_req   = 1'($urandom_range(0, 1));
      fetch_stall = ($urandom_range(0, 3) == 0);
      load_valid  = 1'($urandom_range(0, 1));
      load_addr   = AW'($urandom);
      load_data   = IW'($urandom);
      fetch_addr  = ($urandom_range(0, 3) == 0) ? load_addr : AW'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (busy_o[k] !== (m_cyc[k] < DEP[k]) || ready_o[k] !== (m_cyc[k] >= DEP[k]))
          $display("FAIL rnd_busy[%0d] cyc %0d: got busy %b ready %b", k, i, busy_o[k], ready_o[k]);
        else n_pass++;
        n_checks++;
        if (valid_o[k] !== m_valid[k])
          $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, i, valid_o[k], m_valid[k]);
        else n_pass++;
        n_checks++;
        if (m_valid[k] && instr_o[k] !== m_instr[k])
          $display("FAIL rnd_instr[%0d] cyc %0d: got %h want %h", k, i, instr_o[k], m_instr[k]);
        else n_pass++;
        n_checks++;
        if (aerr_o[k] !== m_aerr[k])
          $display("FAIL rnd_aerr[%0d] cyc %0d: got %b want %b", k, i, aerr_o[k], m_aerr[k]);
        else n_pass++;
        n_checks++;
        if (perr_o[k] !== 1'b0) $display("FAIL rnd_perr[%0d] cyc %0d: got %b want 0", k, i, perr_o[k]);
        else n_pass++;
      end
    end
    idle_inputs();
    tick();
  endtask

`ifdef PROG_MEM_PARITY_EN
  task automatic test_parity();
    load_valid = 1'b1;
    load_addr  = 5'd7;
    load_data  = 16'h1234;
    tick();
    idle_inputs();
    dut32.u_array.mem[7][3] = ~dut32.u_array.mem[7][3];
    fetch_req  = 1'b1;
    fetch_addr = 5'd7;
    tick();
    n_checks++;
    if (valid_o[0] !== 1'b1 || instr_o[0] !== 16'h000F || perr_o[0] !== 1'b1)
      $display("FAIL parity_flip: got %b/%h perr %b want 1/000f perr 1",
               valid_o[0], instr_o[0], perr_o[0]);
    else n_pass++;
    n_checks++;
    if (instr_o[1] !== 16'h1234 || perr_o[1] !== 1'b0)
      $display("FAIL parity_clean: got %h perr %b want 1234 perr 0", instr_o[1], perr_o[1]);
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (perr_o[0] !== 1'b0) $display("FAIL parity_pulse: got %b want 0", perr_o[0]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_load_fetch();
    test_bypass();
    test_out_of_range();
    test_stall_reset();
    test_random();
`ifdef PROG_MEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
